// File: rtl/adc_dual_responder_pkg.sv
// Shared types and defaults for the dual-channel serial ADC responder.
package adc_dual_responder_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        SHIFT   = 2'd2
    } adc_state_t;

    localparam int DEF_DATA_W     = 12;
    localparam int DEF_FRAME_BITS = 16;
    localparam int SYNC_STAGES    = 2;

endpackage

// File: rtl/adc_dual_responder_sync_edge.sv
// Multi-flop synchronizer for one asynchronous master pin, followed by a
// detect register that produces single-cycle rise/fall strobes.
module adc_dual_responder_sync_edge
    import adc_dual_responder_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/adc_dual_responder.sv
// Device-side model of the dual serial ADC: captures two samples on CNVST,
// models conversion latency and shifts both results out during a CS_N frame.
module adc_dual_responder
    import adc_dual_responder_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int LEAD_ZEROS  = 2,
    parameter int FRAME_BITS  = DEF_FRAME_BITS,
    parameter int CONV_CYCLES = 40
) (
    input  logic              clock_50MHz,
    input  logic              RESET_n,
    input  logic              ADC_CNVST,
    input  logic              ADC_CS_N,
    input  logic              ADC_SCLK,
    input  logic              ADC_SEL,
    input  logic [DATA_W-1:0] sample_a,
    input  logic [DATA_W-1:0] sample_b,
    input  logic              clr_err,
    output logic [1:0]        ADC_DOUT,
    output logic              conv_busy,
    output logic              frame_done,
    output logic              overrun
);

    localparam int CNT_W = $clog2(CONV_CYCLES + 1);
    localparam int BIT_W = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] CONV_LOAD  = CNT_W'(CONV_CYCLES);
    localparam logic [BIT_W-1:0] FRAME_FULL = BIT_W'(FRAME_BITS);

    // Places a sample behind the lead zeros, trailing bits padded with zero.
    function automatic logic [FRAME_BITS-1:0] frame_load(input logic [DATA_W-1:0] s);
        logic [FRAME_BITS-1:0] f;
        f = '0;
        f[FRAME_BITS-1-LEAD_ZEROS -: DATA_W] = s;
        return f;
    endfunction

    logic cnvst_rise, cnvst_fall;
    logic cs_rise, cs_fall;
    logic sclk_rise, sclk_fall;
    logic unused_edges;

    adc_dual_responder_sync_edge #(.RST_VAL(1'b0)) u_sync_cnvst (
        .clk(clock_50MHz), .rst_n(RESET_n), .din(ADC_CNVST),
        .rise(cnvst_rise), .fall(cnvst_fall)
    );
    adc_dual_responder_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
        .clk(clock_50MHz), .rst_n(RESET_n), .din(ADC_CS_N),
        .rise(cs_rise), .fall(cs_fall)
    );
    adc_dual_responder_sync_edge #(.RST_VAL(1'b1)) u_sync_sclk (
        .clk(clock_50MHz), .rst_n(RESET_n), .din(ADC_SCLK),
        .rise(sclk_rise), .fall(sclk_fall)
    );

    assign unused_edges = cnvst_fall ^ sclk_rise;

    adc_state_t            state, state_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic [BIT_W-1:0]      bits, bits_n;
    logic [FRAME_BITS-1:0] sh_a, sh_a_n, sh_b, sh_b_n;
    logic [DATA_W-1:0]     cap_a, cap_a_n, cap_b, cap_b_n;
    logic                  ovr_set, done_n;
    logic                  done_p0;

    always_ff @(posedge clock_50MHz or negedge RESET_n) begin
        if (!RESET_n) begin
            state      <= IDLE;
            cnt        <= '0;
            bits       <= '0;
            sh_a       <= '0;
            sh_b       <= '0;
            cap_a      <= '0;
            cap_b      <= '0;
            overrun    <= 1'b0;
            done_p0    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bits       <= bits_n;
            sh_a       <= sh_a_n;
            sh_b       <= sh_b_n;
            cap_a      <= cap_a_n;
            cap_b      <= cap_b_n;
            // A violation in the same cycle as clr_err wins.
            overrun    <= ovr_set | (overrun & ~clr_err);
            // ---- stage p0 -> output: frame_done lags the CS_N rise detect by one cycle
            done_p0    <= done_n;
            frame_done <= done_p0;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bits_n  = bits;
        sh_a_n  = sh_a;
        sh_b_n  = sh_b;
        cap_a_n = cap_a;
        cap_b_n = cap_b;
        ovr_set = 1'b0;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (cs_fall) begin
                    sh_a_n  = frame_load(cap_a);
                    sh_b_n  = frame_load(cap_b);
                    bits_n  = '0;
                    state_n = SHIFT;
                end else if (cnvst_rise) begin
                    cap_a_n = ADC_SEL ? sample_b : sample_a;
                    cap_b_n = ADC_SEL ? sample_a : sample_b;
                    cnt_n   = CONV_LOAD;
                    state_n = CONVERT;
                end
            end
            CONVERT: begin
                if (cs_fall) begin
                    // Reading mid-conversion aborts it and returns zeros.
                    ovr_set = 1'b1;
                    sh_a_n  = '0;
                    sh_b_n  = '0;
                    bits_n  = '0;
                    cnt_n   = '0;
                    state_n = SHIFT;
                end else begin
                    cnt_n = cnt - 1'b1;
                    if (cnt == CNT_W'(1)) state_n = IDLE;
                end
            end
            SHIFT: begin
                if (cnvst_rise) ovr_set = 1'b1;
                if (cs_rise) begin
                    done_n  = (bits == FRAME_FULL);
                    state_n = IDLE;
                end else if (sclk_fall) begin
                    sh_a_n = {sh_a[FRAME_BITS-2:0], 1'b0};
                    sh_b_n = {sh_b[FRAME_BITS-2:0], 1'b0};
                    if (bits != FRAME_FULL) bits_n = bits + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign conv_busy = (state == CONVERT);
    assign ADC_DOUT  = (state == SHIFT) ? {sh_b[FRAME_BITS-1], sh_a[FRAME_BITS-1]} : 2'b00;

endmodule

// File: tb/tb_adc_dual_responder.sv
// Directed bench for adc_dual_responder: vector table of capture/readout
// cases plus hand-written sequences for abort, partial frame and reset.
module tb_adc_dual_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cnvst, cs_n, sclk, sel, clr_err;
    logic [11:0] sa, sb;
    logic [1:0]  dout;
    logic        busy, done, ovr;

    int n_cmp = 0;
    int n_bad = 0;

    always #10 clk = ~clk;

    adc_dual_responder dut (
        .clock_50MHz(clk), .RESET_n(rst_n), .ADC_CNVST(cnvst), .ADC_CS_N(cs_n),
        .ADC_SCLK(sclk), .ADC_SEL(sel), .sample_a(sa), .sample_b(sb),
        .clr_err(clr_err), .ADC_DOUT(dout), .conv_busy(busy),
        .frame_done(done), .overrun(ovr)
    );

    typedef struct {
        logic        sel;
        logic [11:0] a;
        logic [11:0] b;
        logic [15:0] e0;
        logic [15:0] e1;
    } vec_t;

    vec_t vecs[4];

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulse CNVST, check busy starts 3 cycles later and lasts 40 cycles.
    // A non-negative retrig_at re-pulses CNVST and changes sample_a mid-conversion.
    task automatic convert(input string tag, input int retrig_at);
        int n_busy;
        int first;
        n_busy = 0;
        first  = -1;
        cnvst  = 1'b1;
        cyc(2);
        chk({tag, "_busy_pre"}, busy, 0);
        for (int i = 0; i < 60; i++) begin
            cyc(1);
            if (i == 2) cnvst = 1'b0;
            if (retrig_at >= 0 && i == retrig_at) begin
                cnvst = 1'b1;
                sa    = 12'h555;
            end
            if (retrig_at >= 0 && i == retrig_at + 4) cnvst = 1'b0;
            if (busy) begin
                n_busy++;
                if (first < 0) first = i;
            end
        end
        chk({tag, "_busy_len"}, n_busy, 40);
        chk({tag, "_busy_start"}, first, 0);
    endtask

    // Master frame: SCLK 8 clocks high / 8 low, DOUT captured just before each fall.
    task automatic frame(input int nfalls, output logic [15:0] r0, output logic [15:0] r1,
                         output int ndone, output int done_at);
        r0 = '0;
        r1 = '0;
        ndone = 0;
        done_at = -1;
        cs_n = 1'b0;
        cyc(4);
        for (int i = 0; i < nfalls; i++) begin
            r0[15-i] = dout[0];
            r1[15-i] = dout[1];
            sclk = 1'b0;
            cyc(8);
            sclk = 1'b1;
            cyc(8);
        end
        cs_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            if (done) begin
                ndone++;
                done_at = i + 1;
            end
        end
    endtask

    logic [15:0] r0, r1;
    int nd, da;

    initial begin
        vecs[0] = '{sel: 1'b0, a: 12'hABC, b: 12'h123, e0: 16'h2AF0, e1: 16'h048C};
        vecs[1] = '{sel: 1'b1, a: 12'hABC, b: 12'h123, e0: 16'h048C, e1: 16'h2AF0};
        vecs[2] = '{sel: 1'b0, a: 12'hFFF, b: 12'h000, e0: 16'h3FFC, e1: 16'h0000};
        vecs[3] = '{sel: 1'b0, a: 12'h800, b: 12'h001, e0: 16'h2000, e1: 16'h0004};

        rst_n = 1'b0; cnvst = 1'b0; cs_n = 1'b1; sclk = 1'b1;
        sel = 1'b0; clr_err = 1'b0; sa = '0; sb = '0;
        cyc(3);
        chk("rst_dout", dout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovr", ovr, 0);
        rst_n = 1'b1;
        cyc(3);

        // Table: capture then full frame
        for (int v = 0; v < 4; v++) begin
            sel = vecs[v].sel;
            sa  = vecs[v].a;
            sb  = vecs[v].b;
            convert($sformatf("v%0d", v), -1);
            frame(16, r0, r1, nd, da);
            chk($sformatf("v%0d_dout0", v), r0, vecs[v].e0);
            chk($sformatf("v%0d_dout1", v), r1, vecs[v].e1);
            chk($sformatf("v%0d_ndone", v), nd, 1);
            chk($sformatf("v%0d_done_at", v), da, 4);
            chk($sformatf("v%0d_dout_idle", v), dout, 0);
            chk($sformatf("v%0d_ovr", v), ovr, 0);
        end

        // Partial frame then repeat read of the same capture
        sel = 1'b0; sa = 12'hABC; sb = 12'h123;
        convert("part", -1);
        frame(8, r0, r1, nd, da);
        chk("part_dout0", r0[15:8], 8'h2A);
        chk("part_dout1", r1[15:8], 8'h04);
        chk("part_ndone", nd, 0);
        chk("part_dout_idle", dout, 0);
        frame(16, r0, r1, nd, da);
        chk("rep_dout0", r0, 16'h2AF0);
        chk("rep_dout1", r1, 16'h048C);
        chk("rep_ndone", nd, 1);

        // Second CNVST during conversion is ignored
        sa = 12'h9A5; sb = 12'h3C6;
        convert("retrig", 10);
        frame(16, r0, r1, nd, da);
        chk("retrig_dout0", r0, 16'h2694);
        chk("retrig_dout1", r1, 16'h0F18);
        chk("retrig_ovr", ovr, 0);

        // CS_N falls 10 cycles into conversion
        sa = 12'hABC; sb = 12'h123;
        cnvst = 1'b1;
        cyc(3);
        chk("abort_busy_on", busy, 1);
        cnvst = 1'b0;
        cyc(9);
        cs_n = 1'b0;
        cyc(2);
        chk("abort_busy_hold", busy, 1);
        chk("abort_ovr_pre", ovr, 0);
        cyc(1);
        chk("abort_busy_drop", busy, 0);
        chk("abort_ovr_set", ovr, 1);
        frame(16, r0, r1, nd, da);
        chk("abort_dout0", r0, 0);
        chk("abort_dout1", r1, 0);
        chk("abort_ovr_sticky", ovr, 1);
        clr_err = 1'b1;
        cyc(1);
        clr_err = 1'b0;
        chk("abort_ovr_clr", ovr, 0);

        // CNVST during SHIFT coinciding with clr_err keeps overrun set
        cs_n = 1'b0;
        cyc(4);
        cnvst = 1'b1;
        cyc(2);
        clr_err = 1'b1;
        cyc(1);
        clr_err = 1'b0;
        cnvst = 1'b0;
        chk("clr_race_ovr", ovr, 1);
        cs_n = 1'b1;
        cyc(6);
        clr_err = 1'b1;
        cyc(1);
        clr_err = 1'b0;
        chk("clr_race_cleared", ovr, 0);

        // Reset in the middle of a frame
        sel = 1'b0; sa = 12'hABC; sb = 12'h123;
        convert("rst", -1);
        cs_n = 1'b0;
        cyc(4);
        for (int i = 0; i < 2; i++) begin
            sclk = 1'b0;
            cyc(8);
            sclk = 1'b1;
            cyc(8);
        end
        chk("mid_dout", dout, 2'b01);
        cnvst = 1'b1;
        cyc(4);
        cnvst = 1'b0;
        chk("mid_ovr", ovr, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_dout", dout, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_ovr", ovr, 0);
        cyc(2);
        cs_n = 1'b1;
        rst_n = 1'b1;
        cyc(5);
        frame(16, r0, r1, nd, da);
        chk("postrst_dout0", r0, 0);
        chk("postrst_dout1", r1, 0);
        chk("postrst_ndone", nd, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/adc_dual_responder.md
# adc_dual_responder

Synthesizable responder for the dual-channel serial ADC link: the device end of the CNVST/CS_N/SCLK/DOUT protocol that our ADC controller masters. It latches two 12-bit samples on a convert strobe, models conversion latency, and shifts both results MSB-first on the two DOUT lines during a chip-select frame. It replaces the physical ADC in simulation and in loop-back bring-up builds of the pong top level, so paddle input paths can run without analog hardware.

## Interface
- DATA_W, 12, sample width per channel
- LEAD_ZEROS, 2, zero bits sent before the MSB
- FRAME_BITS, 16, SCLK falling edges per full frame (≥ LEAD_ZEROS+DATA_W)
- CONV_CYCLES, 40, clock cycles from accepted CNVST to data ready
- clock_50MHz  in  1  system clock
- RESET_n  in  1  reset, asynchronous, active-low
- ADC_CNVST  in  1  convert strobe from master, rising edge starts conversion
- ADC_CS_N  in  1  frame select, active-low
- ADC_SCLK  in  1  serial clock from master, idle high
- ADC_SEL  in  1  channel swap: 1 puts sample_b on DOUT[0], sample_a on DOUT[1]
- sample_a  in  DATA_W  analog value modelled on channel A
- sample_b  in  DATA_W  analog value modelled on channel B
- clr_err  in  1  synchronous clear of overrun
- ADC_DOUT  out  2  serial data, bit 0 = channel A (unswapped), bit 1 = channel B
- conv_busy  out  1  high during conversion
- frame_done  out  1  one-cycle pulse after a complete frame
- overrun  out  1  sticky protocol-violation flag

## Operation
- ADC_CNVST, ADC_CS_N, ADC_SCLK each pass through a 2-FF synchronizer (reset value 0, 1, 1) plus one edge-detect register.
- States: IDLE, CONVERT, SHIFT.
- IDLE: CNVST rise → capture sample_a/sample_b (ADC_SEL applied at capture), load counter with CONV_CYCLES, go CONVERT. CS_N fall → load shift registers from the last captured pair (repeat read), bit count 0, go SHIFT.
- CONVERT: counter decrements each cycle; at 0 → IDLE, data ready. CNVST rise ignored. CS_N fall → overrun=1, conversion aborted, shift registers loaded with zeros, go SHIFT.
- SHIFT: each shift register is FRAME_BITS wide, loaded as {LEAD_ZEROS zeros, sample, trailing zeros}; ADC_DOUT = shift MSBs. Each synced SCLK fall → shift left one, bit count +1 (saturates at FRAME_BITS). CNVST rise → overrun=1, ignored. CS_N rise → frame_done pulse if bit count == FRAME_BITS, else no pulse (aborted frame); go IDLE.
- ADC_DOUT is 0 whenever state ≠ SHIFT.
- overrun cleared only by clr_err; a violation and clr_err in the same cycle leaves overrun=1.
- Reset mid-operation: all state returns to reset values immediately; captured samples cleared to 0.

## Timing
- Reset values: ADC_DOUT=0, conv_busy=0, frame_done=0, overrun=0, state IDLE.
- Pin edge → internal action: 3 clock cycles (2 sync + 1 detect).
- conv_busy rises 3 cycles after CNVST rise at pin, stays high exactly CONV_CYCLES cycles.
- ADC_DOUT updates 3 cycles after each SCLK falling edge at pin; master samples on SCLK rise. Master requirement: SCLK high and low phases ≥ 4 clocks each (≤ 6.25 MHz).
- First ADC_DOUT value (lead zero) valid 3 cycles after CS_N fall; MSB appears after the LEAD_ZEROS-th SCLK fall.
- frame_done asserted the cycle after CS_N rise is detected (4 cycles after pin edge).

## Structure
- Shared package: state enum (IDLE/CONVERT/SHIFT), FRAME_BITS/DATA_W defaults, sync-stage count constant.
- One sub-module: sync_edge (2-FF synchronizer + rise/fall detect), instantiated three times.

## Test plan
- CNVST pulse, sample_a=12'hABC, sample_b=12'h123, SEL=0, then 16-clock frame at 3.125 MHz → DOUT[0] reads 00_1010_1011_1100_00, DOUT[1] reads 00_0001_0010_0011_00, one frame_done, overrun=0.
- Same with SEL=1 → channels swapped on DOUT.
- CS_N falls 10 cycles into conversion → overrun=1, both lines shift all zeros, conv_busy drops at CS_N detect; clr_err → overrun=0.
- CS_N raised after 8 SCLK falls → no frame_done, DOUT=0, next full frame (no new CNVST) repeats last captured samples.
- Second CNVST during CONVERT → conv_busy still exactly 40 cycles from the first, data from first capture.
- RESET_n asserted mid-SHIFT → DOUT=0, IDLE, outputs at reset values; following frame without CNVST shifts zeros.
